cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Fetch/decode/execute controller for the mini CPU.
- Owns PC, IR, accumulator AR and compare flags, and sequences every access to the shared 256x16 word memory through a single request/ready port.
- Sits between the memory block and the top level. START launches a program at START_PC; the block runs until a HALT word or an illegal opcode.

Parameters:
- START_PC, 100, word address of the first instruction fetched after START
- ADDR_W, 8, memory address width
- DATA_W, 16, data/instruction width

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  one-cycle pulse; honoured only when not BUSY
- MEM_ADDR  out  ADDR_W  memory word address
- MEM_RD  out  1  read request
- MEM_WR  out  1  write request
- MEM_WDATA  out  DATA_W  write data (AR)
- MEM_RDATA  in  DATA_W  read data, valid in the cycle MEM_READY=1
- MEM_READY  in  1  memory accepts or completes the current request
- AR  out  DATA_W  accumulator
- PC  out  ADDR_W  program counter
- GREAT / EQUAL / LESS  out  1 each  compare flags
- BUSY  out  1  program running
- HALTED  out  1  stopped on a HALT word
- ERROR  out  1  stopped on an illegal instruction

Behaviour:
- Reset (async, immediate) values:
  - state IDLE
  - PC=START_PC
  - AR=0, IR=0
  - all flags 0
  - MEM_RD=0, MEM_WR=0, MEM_ADDR=0, MEM_WDATA=0
  - BUSY=0, HALTED=0, ERROR=0
  - Reset mid-access drops the request the same instant; no write completes.
- Instruction word: [15:12] class, [11:8] op, [7:0] operand address.
  - class 0000 = HALT.
  - class 0001 = op table below.
  - Any other class = illegal.
- Op table:
  - 0 LOAD: AR=M
  - 1 ADD: AR=AR+M
  - 2 SUB: AR=AR-M
  - 3 MUL: AR=low 16 bits of AR*M
  - 4 SHL: AR=AR<<M[3:0]
  - 5 SHR: AR=AR>>M[3:0] (logical)
  - 6 INC: AR=AR+1, no operand read
  - 7 DEC: AR=AR-1, no operand read
  - 8 CMP: unsigned compare of AR vs M; set exactly one of GREAT/EQUAL/LESS; AR unchanged
  - F STORE: M[addr]=AR
  - 9-E: illegal
- All arithmetic wraps mod 2^16. Flags change only on CMP.
- States:
  - IDLE: on START -> FETCH; PC=START_PC, HALTED=0, ERROR=0, BUSY=1; AR and flags retained.
  - FETCH: MEM_RD=1, MEM_ADDR=PC; hold until MEM_READY=1, then IR=MEM_RDATA, PC=PC+1 (255 wraps to 0) -> DECODE.
  - DECODE (1 cycle):
    - HALT -> IDLE with HALTED=1.
    - illegal -> IDLE with ERROR=1.
    - INC/DEC -> EXECUTE.
    - STORE -> WRITE.
    - otherwise -> OPERAND.
  - OPERAND: MEM_RD=1, MEM_ADDR=IR[7:0]; on MEM_READY latch operand -> EXECUTE.
  - EXECUTE (1 cycle): update AR or flags -> FETCH.
  - WRITE: MEM_WR=1, MEM_ADDR=IR[7:0], MEM_WDATA=AR; hold until MEM_READY -> FETCH.
  - Leaving any of HALT/illegal -> IDLE deasserts BUSY.
- Handshake:
  - MEM_RD and MEM_WR are never both 1.
  - MEM_ADDR and MEM_WDATA stay stable while a request is pending.
  - The request deasserts in the cycle after the one where MEM_READY was sampled high.
  - MEM_READY outside a request is ignored.
- Latency with MEM_READY tied high, START to first FETCH = 1 cycle:
  - operand instructions: 4 cycles
  - INC/DEC: 3 cycles
  - STORE: 3 cycles
  - HALT: 2 cycles to HALTED=1
- START while BUSY is ignored. START in the same cycle as a halt transition is ignored; a new START is needed.

Test Plan:
- Program at 100..111 per op table with data 16,4,8,7,4,3,300,306,400 at 1..9, HALT at 112, MEM_READY=1 -> AR sequence 16,20,160,153,2448,306,307,306; CMP vs 300 gives GREAT, vs 306 EQUAL, vs 400 LESS; mem[10]=306; HALTED=1; PC=113.
- Same program with MEM_READY low for 3 cycles on every request -> identical final state; MEM_ADDR/MEM_RD/MEM_WR stable throughout each wait; total cycles = ready-high count + 3 x number of accesses.
- Word 0x3000 at 100 -> ERROR=1, HALTED=0, BUSY=0, AR unchanged, PC=101.
- START_PC=255, mem[255]=INC, mem[0]=HALT -> AR increments by 1, fetch wraps to address 0, PC=1, HALTED=1.
- Assert RST while a WRITE has MEM_READY=0 -> MEM_WR=0 immediately, target word unchanged, all outputs at reset values.
- START pulsed while BUSY -> no restart, PC progression unchanged; START after HALTED -> rerun from START_PC with AR retained.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the mini CPU. Owns PC, IR, the accumulator and the
// compare flags, and drives the single request/ready port of the shared word memory.
module cpu_sequencer #(
    parameter int unsigned START_PC = 100,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_READY,
    output logic [DATA_W-1:0] AR,
    output logic [ADDR_W-1:0] PC,
    output logic              GREAT,
    output logic              EQUAL,
    output logic              LESS,
    output logic              BUSY,
    output logic              HALTED,
    output logic              ERROR
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StOperand,
        StExecute,
        StWrite
    } state_e;

    localparam logic [3:0] ClsHalt = 4'h0;
    localparam logic [3:0] ClsOps  = 4'h1;

    localparam logic [3:0] OpLoad  = 4'h0;
    localparam logic [3:0] OpAdd   = 4'h1;
    localparam logic [3:0] OpSub   = 4'h2;
    localparam logic [3:0] OpMul   = 4'h3;
    localparam logic [3:0] OpShl   = 4'h4;
    localparam logic [3:0] OpShr   = 4'h5;
    localparam logic [3:0] OpInc   = 4'h6;
    localparam logic [3:0] OpDec   = 4'h7;
    localparam logic [3:0] OpCmp   = 4'h8;
    localparam logic [3:0] OpStore = 4'hF;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ar_q, ar_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [2:0]        flags_q, flags_d;   // {great, equal, less}
    logic              halted_q, halted_d;
    logic              error_q, error_d;

    logic [3:0]        ir_cls;
    logic [3:0]        ir_op;
    logic [ADDR_W-1:0] ir_addr;

    assign ir_cls  = ir_q[DATA_W-1 -: 4];
    assign ir_op   = ir_q[DATA_W-5 -: 4];
    assign ir_addr = ir_q[ADDR_W-1:0];

    // State and datapath registers; reset drops any pending memory request at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            pc_q     <= ADDR_W'(START_PC);
            ir_q     <= '0;
            ar_q     <= '0;
            opnd_q   <= '0;
            flags_q  <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ar_q     <= ar_d;
            opnd_q   <= opnd_d;
            flags_q  <= flags_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    end

    // Next-state, datapath update and memory-port outputs, all decoded from the current state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ar_d      = ar_q;
        opnd_d    = opnd_q;
        flags_d   = flags_q;
        halted_d  = halted_q;
        error_d   = error_q;
        MEM_RD    = 1'b0;
        MEM_WR    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d  = StFetch;
                    pc_d     = ADDR_W'(START_PC);
                    halted_d = 1'b0;
                    error_d  = 1'b0;
                end
            end
            StFetch: begin
                MEM_RD   = 1'b1;
                MEM_ADDR = pc_q;
                if (MEM_READY) begin
                    ir_d    = MEM_RDATA;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (ir_cls == ClsHalt) begin
                    halted_d = 1'b1;
                    state_d  = StIdle;
                end else if (ir_cls != ClsOps || (ir_op >= 4'h9 && ir_op <= 4'hE)) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else if (ir_op == OpInc || ir_op == OpDec) begin
                    state_d = StExecute;
                end else if (ir_op == OpStore) begin
                    state_d = StWrite;
                end else begin
                    state_d = StOperand;
                end
            end
            StOperand: begin
                MEM_RD   = 1'b1;
                MEM_ADDR = ir_addr;
                if (MEM_READY) begin
                    opnd_d  = MEM_RDATA;
                    state_d = StExecute;
                end
            end
            StExecute: begin
                unique case (ir_op)
                    OpLoad: ar_d = opnd_q;
                    OpAdd:  ar_d = ar_q + opnd_q;
                    OpSub:  ar_d = ar_q - opnd_q;
                    OpMul:  ar_d = ar_q * opnd_q;
                    OpShl:  ar_d = ar_q << opnd_q[3:0];
                    OpShr:  ar_d = ar_q >> opnd_q[3:0];
                    OpInc:  ar_d = ar_q + DATA_W'(1);
                    OpDec:  ar_d = ar_q - DATA_W'(1);
                    OpCmp: begin
                        if (ar_q > opnd_q) begin
                            flags_d = 3'b100;
                        end else if (ar_q == opnd_q) begin
                            flags_d = 3'b010;
                        end else begin
                            flags_d = 3'b001;
                        end
                    end
                    default: ;
                endcase
                state_d = StFetch;
            end
            StWrite: begin
                MEM_WR    = 1'b1;
                MEM_ADDR  = ir_addr;
                MEM_WDATA = ar_q;
                if (MEM_READY) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign AR     = ar_q;
    assign PC     = pc_q;
    assign GREAT  = flags_q[2];
    assign EQUAL  = flags_q[1];
    assign LESS   = flags_q[0];
    assign BUSY   = (state_q != StIdle);
    assign HALTED = halted_q;
    assign ERROR  = error_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: an instruction-level model predicts every memory
// access (kind, address, write data) together with AR, flags and PC at that access.
module tb_cpu_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        START2 = 1'b0;

    always #5 CLK = ~CLK;

    // Main instance, START_PC = 100
    logic [7:0]  mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ready = 1'b1;
    logic [15:0] ar;
    logic [7:0]  pc;
    logic        great, equal, less, busy, halted, error;

    cpu_sequencer #(.START_PC(100), .ADDR_W(8), .DATA_W(16)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .MEM_ADDR(mem_addr), .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MEM_WDATA(mem_wdata),
        .MEM_RDATA(mem_rdata), .MEM_READY(mem_ready),
        .AR(ar), .PC(pc), .GREAT(great), .EQUAL(equal), .LESS(less),
        .BUSY(busy), .HALTED(halted), .ERROR(error)
    );

    // Wrap instance, START_PC = 255, memory always ready
    logic [7:0]  addr2;
    logic        rd2, wr2;
    logic [15:0] wdata2, rdata2;
    logic        ready2;
    logic [15:0] ar2;
    logic [7:0]  pc2;
    logic        great2, equal2, less2, busy2, halted2, error2;

    assign ready2 = 1'b1;

    cpu_sequencer #(.START_PC(255), .ADDR_W(8), .DATA_W(16)) u_wrap (
        .CLK(CLK), .RST(RST), .START(START2),
        .MEM_ADDR(addr2), .MEM_RD(rd2), .MEM_WR(wr2), .MEM_WDATA(wdata2),
        .MEM_RDATA(rdata2), .MEM_READY(ready2),
        .AR(ar2), .PC(pc2), .GREAT(great2), .EQUAL(equal2), .LESS(less2),
        .BUSY(busy2), .HALTED(halted2), .ERROR(error2)
    );

    logic [15:0] mem  [256];
    logic [15:0] mem2 [256];
    assign mem_rdata = mem[mem_addr];
    assign rdata2    = mem2[addr2];

    always @(posedge CLK) begin
        if (mem_wr && mem_ready) mem[mem_addr] <= mem_wdata;
    end

    // Memory responder: each request sees wait_cycles low cycles, then one ready cycle.
    int wait_cycles = 0;
    int wcnt = 0;
    always @(negedge CLK) begin
        #1;
        if (mem_rd || mem_wr) begin
            if (wcnt >= wait_cycles) begin
                mem_ready = 1'b1;
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b1;   // ready outside a request must be ignored
            wcnt = 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] ar;
        logic [2:0]  fl;
        logic [7:0]  pc;
    } acc_t;

    acc_t        exp_q[$];
    logic [15:0] mm [256];
    logic [15:0] m_ar = 16'd0;
    logic [2:0]  m_fl = 3'd0;
    logic [7:0]  m_pc;
    bit          m_halt, m_err;

    task automatic push_acc(input bit wr, input logic [7:0] addr, input logic [15:0] wd);
        acc_t e;
        e.wr = wr; e.addr = addr; e.wdata = wd; e.ar = m_ar; e.fl = m_fl; e.pc = m_pc;
        exp_q.push_back(e);
    endtask

    task automatic model_run(input logic [7:0] spc);
        logic [15:0] ir;
        logic [15:0] opnd;
        logic [3:0]  cls, op;
        logic [7:0]  a;
        for (int i = 0; i < 256; i++) mm[i] = mem[i];
        m_pc = spc; m_halt = 0; m_err = 0; opnd = 16'd0;
        for (int n = 0; n < 1000 && !m_halt && !m_err; n++) begin
            push_acc(1'b0, m_pc, 16'd0);
            ir = mm[m_pc];
            m_pc = m_pc + 8'd1;
            cls = ir[15:12]; op = ir[11:8]; a = ir[7:0];
            if (cls == 4'd0) m_halt = 1;
            else if (cls != 4'd1 || (op >= 4'd9 && op <= 4'd14)) m_err = 1;
            else if (op == 4'd15) begin
                push_acc(1'b1, a, m_ar);
                mm[a] = m_ar;
            end else begin
                if (op != 4'd6 && op != 4'd7) begin
                    push_acc(1'b0, a, 16'd0);
                    opnd = mm[a];
                end
                case (op)
                    4'd0: m_ar = opnd;
                    4'd1: m_ar = m_ar + opnd;
                    4'd2: m_ar = m_ar - opnd;
                    4'd3: m_ar = m_ar * opnd;
                    4'd4: m_ar = m_ar << opnd[3:0];
                    4'd5: m_ar = m_ar >> opnd[3:0];
                    4'd6: m_ar = m_ar + 16'd1;
                    4'd7: m_ar = m_ar - 16'd1;
                    default: m_fl = (m_ar > opnd) ? 3'b100 : (m_ar == opnd) ? 3'b010 : 3'b001;
                endcase
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    bit          chk_en = 0;
    bit          trace_en = 0;
    logic [15:0] ar_trace[$];
    logic [2:0]  fl_trace[$];
    bit          p_pend = 0;
    logic [25:0] p_req;

    always @(negedge CLK) begin
        acc_t e;
        #2;
        if (chk_en) begin
            check("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
            if (p_pend) check("req_stable", {6'd0, mem_rd, mem_wr, mem_addr, mem_wdata},
                              {6'd0, p_req});
            if ((mem_rd || mem_wr) && mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", {23'd0, mem_wr, mem_addr}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_kind_addr", {23'd0, mem_wr, mem_addr}, {23'd0, e.wr, e.addr});
                    if (e.wr) check("acc_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
                    check("acc_ar", {16'd0, ar}, {16'd0, e.ar});
                    check("acc_flags", {29'd0, great, equal, less}, {29'd0, e.fl});
                    check("acc_pc", {24'd0, pc}, {24'd0, e.pc});
                end
                if (trace_en && mem_rd && mem_addr == pc) begin
                    ar_trace.push_back(ar);
                    fl_trace.push_back({great, equal, less});
                end
            end
            p_pend = (mem_rd || mem_wr) && !mem_ready;
            p_req  = {mem_rd, mem_wr, mem_addr, mem_wdata};
        end else begin
            p_pend = 0;
        end
    end

    logic [7:0] wtrace[$];
    always @(negedge CLK) begin
        #2;
        if (rd2) wtrace.push_back(addr2);
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = 16'd0;
        mem[1] = 16'd16;  mem[2] = 16'd4;   mem[3] = 16'd8;
        mem[4] = 16'd7;   mem[5] = 16'd4;   mem[6] = 16'd3;
        mem[7] = 16'd300; mem[8] = 16'd306; mem[9] = 16'd400;
        mem[100] = 16'h1001; mem[101] = 16'h1102; mem[102] = 16'h1303;
        mem[103] = 16'h1204; mem[104] = 16'h1405; mem[105] = 16'h1506;
        mem[106] = 16'h1600; mem[107] = 16'h1700; mem[108] = 16'h1807;
        mem[109] = 16'h1808; mem[110] = 16'h1809; mem[111] = 16'h1F0A;
        mem[112] = 16'h0000;
    endtask

    task automatic run_main(input int budget, input bit poke, output int cycles);
        bit done = 0;
        cycles = 0;
        @(negedge CLK);
        START = 1'b1;
        while (!done && cycles < budget) begin
            @(negedge CLK);
            cycles++;
            START = poke && (cycles == 5 || cycles == 20 || cycles == 60);
            if (!busy) done = 1;
        end
        START = 1'b0;
        check("run_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic check_final_prog(input string tag);
        check({tag, "_ar"}, {16'd0, ar}, 32'd306);
        check({tag, "_flags"}, {29'd0, great, equal, less}, 32'b001);
        check({tag, "_mem10"}, {16'd0, mem[10]}, 32'd306);
        check({tag, "_halted"}, {31'd0, halted}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_pc"}, {24'd0, pc}, 32'd113);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    logic [15:0] lit_ar [8] = '{16'd16, 16'd20, 16'd160, 16'd153, 16'd2448, 16'd306,
                                16'd307, 16'd306};
    logic [2:0]  lit_fl [3] = '{3'b100, 3'b010, 3'b001};

    initial begin
        int  cyc;
        bit  done;
        for (int i = 0; i < 256; i++) mem2[i] = 16'd0;
        mem2[255] = 16'h1600;   // INC
        mem2[0]   = 16'h0000;   // HALT

        // Reset values
        #3 RST = 1'b1;
        #1;
        check("rst_outputs", {24'd0, mem_rd, mem_wr, busy, halted, error, great, equal, less},
              32'd0);
        check("rst_addr_wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
        check("rst_ar", {16'd0, ar}, 32'd0);
        check("rst_pc", {24'd0, pc}, 32'd100);
        check("rst_pc_wrap_inst", {24'd0, pc2}, 32'd255);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Run A: ready tied high
        load_prog();
        model_run(8'd100);
        chk_en = 1; trace_en = 1;
        run_main(400, 1'b0, cyc);
        trace_en = 0;
        check("A_cycles", cyc, 32'd48);
        check_final_prog("A");
        check("A_fetch_count", ar_trace.size(), 32'd13);
        if (ar_trace.size() == 13) begin
            for (int i = 0; i < 8; i++) check("A_ar_seq", {16'd0, ar_trace[i+1]},
                                              {16'd0, lit_ar[i]});
            for (int i = 0; i < 3; i++) check("A_cmp_flags", {29'd0, fl_trace[i+9]},
                                              {29'd0, lit_fl[i]});
        end

        // Run B: 3 wait cycles per access, START poked while busy, AR retained
        load_prog();
        wait_cycles = 3;
        model_run(8'd100);
        run_main(1000, 1'b1, cyc);
        check("B_cycles", cyc, 32'd117);
        check_final_prog("B");

        // Run C: illegal class word
        wait_cycles = 0;
        mem[100] = 16'h3000;
        model_run(8'd100);
        run_main(100, 1'b0, cyc);
        check("C_error", {31'd0, error}, 32'd1);
        check("C_halted", {31'd0, halted}, 32'd0);
        check("C_busy", {31'd0, busy}, 32'd0);
        check("C_ar", {16'd0, ar}, 32'd306);
        check("C_pc", {24'd0, pc}, 32'd101);
        check("C_queue_empty", exp_q.size(), 32'd0);

        // Run D: fetch wraps from 255 to 0
        @(negedge CLK); START2 = 1'b1;
        @(negedge CLK); START2 = 1'b0;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge CLK);
            if (!busy2) done = 1;
        end
        check("D_timeout", {31'd0, done}, 32'd1);
        check("D_ar", {16'd0, ar2}, 32'd1);
        check("D_pc", {24'd0, pc2}, 32'd1);
        check("D_halted", {31'd0, halted2}, 32'd1);
        check("D_fetches", wtrace.size(), 32'd2);
        if (wtrace.size() == 2) begin
            check("D_fetch0", {24'd0, wtrace[0]}, 32'd255);
            check("D_fetch1", {24'd0, wtrace[1]}, 32'd0);
        end

        // Run E: reset while a write is stalled
        mem[10] = 16'h1234;
        mem[100] = 16'h1001; mem[101] = 16'h1F0A; mem[102] = 16'h0000;
        wait_cycles = 10;
        model_run(8'd100);
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLK);
            if (mem_wr) done = 1;
        end
        check("E_write_seen", {31'd0, done}, 32'd1);
        chk_en = 0;
        exp_q.delete();
        #2 RST = 1'b1;
        #1;
        check("E_rst_wr", {31'd0, mem_wr}, 32'd0);
        check("E_rst_outputs", {24'd0, mem_rd, mem_wr, busy, halted, error, great, equal, less},
              32'd0);
        check("E_rst_addr_wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
        check("E_rst_ar_pc", {8'd0, ar, pc}, {8'd0, 16'd0, 8'd100});
        repeat (3) @(negedge CLK);
        check("E_mem10_kept", {16'd0, mem[10]}, 32'h1234);
        RST = 1'b0;
        m_ar = 16'd0; m_fl = 3'd0;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
